jls_frame_sequencer: RTL and testbench
======================================

JLS_FRAME_SEQUENCER -- requirements
Module: jls_frame_sequencer

Interface
REQ-001 SHALL have parameter SOF_CYCLES, default 13, number of consecutive cycles o_sof is held per frame.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 16, number of idle cycles driven to the encoder after the last pixel.
REQ-003 SHALL have parameter NUM_BUBBLES, default 0, number of idle cycles inserted after every accepted pixel.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_start, input, 1, frame start request pulse.
REQ-007 SHALL have port i_w, input, 14, frame width minus 1, sampled with i_start.
REQ-008 SHALL have port i_h, input, 14, frame height minus 1, sampled with i_start.
REQ-009 SHALL have ports i_pvalid (input, 1), i_pdata (input, 8) and o_pready (output, 1), the upstream pixel handshake; a pixel transfers when i_pvalid and o_pready are both 1 on a rising edge.
REQ-010 SHALL have ports o_sof (output, 1), o_w (output, 14), o_h (output, 14), o_e (output, 1) and o_x (output, 8), driving the encoder's i_sof, i_w, i_h, i_e and i_x.
REQ-011 SHALL have ports i_enc_e (input, 1) and i_enc_last (input, 1), the encoder's o_e and o_last.
REQ-012 SHALL have ports o_busy (output, 1, frame in progress), o_done (output, 1, one-cycle frame-complete pulse), o_err (output, 1, one-cycle size-reject pulse) and o_words (output, 24, encoder words counted for the current or last frame).

Function
REQ-013 SHALL implement states IDLE, SOF, FEED, BUBBLE, FLUSH and WAIT_LAST.
REQ-014 In IDLE, i_start with i_w<4 or i_h>16382 SHALL pulse o_err the next cycle, remain in IDLE and leave o_busy=0.
REQ-015 In IDLE, i_start with a valid size SHALL capture i_w/i_h, clear the pixel counter and o_words, set o_busy=1 and enter SOF on the next edge.
REQ-016 In SOF, o_sof SHALL be 1, o_w/o_h SHALL equal the captured values, and o_e/o_x SHALL be 0 for exactly SOF_CYCLES cycles, then the block SHALL enter FEED.
REQ-017 Outside SOF, o_sof, o_w and o_h SHALL be 0.
REQ-018 o_pready SHALL be 1 only in FEED; it is a registered output, so it is never combinationally dependent on i_pvalid.
REQ-019 A transfer SHALL drive o_e=1 and o_x=i_pdata on the following cycle (1-cycle latency); in every other cycle o_e=0 and o_x=0.
REQ-020 FEED with i_pvalid=0 SHALL hold state, with o_e=0; upstream stalls are the only other source of encoder bubbles.
REQ-021 After each transfer, when NUM_BUBBLES>0 the block SHALL spend exactly NUM_BUBBLES cycles in BUBBLE with o_pready=0 before returning to FEED.
REQ-022 The pixel counter SHALL be 28 bits and count transfers; the transfer that brings it to (i_w+1)*(i_h+1) SHALL move the block to FLUSH, after any bubbles, with no further o_pready.
REQ-023 FLUSH SHALL hold all encoder inputs at 0 for FLUSH_CYCLES cycles, then the block SHALL enter WAIT_LAST.
REQ-024 o_words SHALL increment on every cycle i_enc_e=1 while o_busy=1, saturating at 2^24-1, in any state.
REQ-025 In FLUSH or WAIT_LAST, i_enc_e=1 with i_enc_last=1 SHALL record completion; at the end of FLUSH, or immediately if in WAIT_LAST, the block SHALL pulse o_done for 1 cycle, clear o_busy and return to IDLE.
REQ-026 i_start while o_busy=1 SHALL be ignored, with no capture and no o_err.
REQ-027 i_enc_last seen before FLUSH SHALL be ignored.
REQ-028 o_done and i_start SHALL not interact in the same cycle: i_start is accepted only from IDLE, on the cycle after o_done.

Reset
REQ-029 rstn=0 SHALL asynchronously force IDLE, clear all counters and force every output to 0, including o_words and o_pready.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no o_done; after release, the next valid i_start begins a fresh frame.

Verification
REQ-031 i_w=4, i_h=0, pvalid always 1 -> 13 cycles o_sof=1 with o_w=4, o_h=0; then 5 consecutive o_e pulses; then 16 idle cycles; o_done follows i_enc_last.
REQ-032 i_w=3 -> o_err=1 for 1 cycle, o_busy stays 0, o_sof never asserts.
REQ-033 NUM_BUBBLES=2, frame 5x2 -> 10 o_e pulses, each followed by exactly 2 idle cycles.
REQ-034 i_pvalid toggled randomly on a 5x3 frame -> o_x sequence equals the accepted pixel sequence, exactly 15 pulses; i_start applied mid-frame is ignored.
REQ-035 i_enc_e high for 37 cycles with i_enc_last on the 37th -> o_words=37 and o_done=1 for 1 cycle.
REQ-036 rstn dropped during FEED -> all outputs 0 immediately; a new 8x8 frame then runs to o_done.

Source files
------------

// File: rtl/jls_frame_sequencer.sv
// Frame sequencer in front of a JPEG-LS encoder core: issues the start-of-frame
// header cycles, paces upstream pixels into the encoder (optionally with idle
// bubbles), flushes the encoder pipeline and waits for its last word.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no frame; waits for i_start with an acceptable size
// SOF       | o_sof held with captured o_w/o_h for SOF_CYCLES cycles
// FEED      | o_pready=1; accepts one pixel per handshake
// BUBBLE    | NUM_BUBBLES idle cycles after each accepted pixel
// FLUSH     | encoder inputs held at 0 for FLUSH_CYCLES idle cycles
// WAIT_LAST | waits for the encoder's last word, then completes the frame
module jls_frame_sequencer #(
    parameter int SOF_CYCLES   = 13,
    parameter int FLUSH_CYCLES = 16,
    parameter int NUM_BUBBLES  = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_start,
    input  logic [13:0] i_w,
    input  logic [13:0] i_h,
    input  logic        i_pvalid,
    input  logic [7:0]  i_pdata,
    output logic        o_pready,
    output logic        o_sof,
    output logic [13:0] o_w,
    output logic [13:0] o_h,
    output logic        o_e,
    output logic [7:0]  o_x,
    input  logic        i_enc_e,
    input  logic        i_enc_last,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [23:0] o_words
);

    typedef enum logic [2:0] {IDLE, SOF, FEED, BUBBLE, FLUSH, WAIT_LAST} state_t;

    // Timer reload values (terminal count is zero).
    // Entering FLUSH straight from FEED, the first FLUSH cycle still carries the
    // final pixel on o_e, so one extra cycle is added to keep FLUSH_CYCLES idle
    // cycles after it. From BUBBLE the final pixel has already gone out.
    localparam logic [15:0] SOF_LD        = 16'((SOF_CYCLES > 0) ? SOF_CYCLES - 1 : 0);
    localparam logic [15:0] FLUSH_LD_FEED = 16'(FLUSH_CYCLES);
    localparam logic [15:0] FLUSH_LD_BUB  = 16'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [15:0] BUB_LD        = 16'((NUM_BUBBLES > 0) ? NUM_BUBBLES - 1 : 0);

    state_t      state, state_nxt;
    logic [15:0] tmr, tmr_nxt;
    logic [13:0] w_q, h_q;
    logic [27:0] pix_cnt, pix_total, size_in;
    logic        done_seen;
    logic        start_req, size_bad, start_ok;
    logic        xfer, last_xfer, enc_last_hit, fin;

    // o_done blocks i_start so a new frame only starts the cycle after completion
    assign start_req    = (state == IDLE) && i_start && !o_done;
    assign size_bad     = (i_w < 14'd4) || (i_h > 14'd16382);
    assign start_ok     = start_req && !size_bad;
    assign size_in      = (28'(i_w) + 28'd1) * (28'(i_h) + 28'd1);
    assign xfer         = o_pready && i_pvalid;
    assign last_xfer    = xfer && ((pix_cnt + 28'd1) == pix_total);
    assign enc_last_hit = i_enc_e && i_enc_last;

    assign o_busy = (state != IDLE);
    assign o_sof  = (state == SOF);
    assign o_w    = o_sof ? w_q : 14'd0;
    assign o_h    = o_sof ? h_q : 14'd0;

    // State and phase timer registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            tmr   <= 16'd0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // Next-state and timer reload/decrement
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = SOF;
                    tmr_nxt   = SOF_LD;
                end
            end
            SOF: begin
                if (tmr == 16'd0) state_nxt = FEED;
                else              tmr_nxt   = tmr - 16'd1;
            end
            FEED: begin
                if (xfer) begin
                    if (NUM_BUBBLES > 0) begin
                        state_nxt = BUBBLE;
                        tmr_nxt   = BUB_LD;
                    end else if (last_xfer) begin
                        state_nxt = FLUSH;
                        tmr_nxt   = FLUSH_LD_FEED;
                    end
                end
            end
            BUBBLE: begin
                if (tmr == 16'd0) begin
                    if (pix_cnt == pix_total) begin
                        state_nxt = FLUSH;
                        tmr_nxt   = FLUSH_LD_BUB;
                    end else begin
                        state_nxt = FEED;
                    end
                end else begin
                    tmr_nxt = tmr - 16'd1;
                end
            end
            FLUSH: begin
                if (tmr == 16'd0) begin
                    if (done_seen || enc_last_hit) begin
                        fin       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_LAST;
                    end
                end else begin
                    tmr_nxt = tmr - 16'd1;
                end
            end
            WAIT_LAST: begin
                if (enc_last_hit) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame capture, pixel/word counters and registered handshake/encoder outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_q       <= 14'd0;
            h_q       <= 14'd0;
            pix_total <= 28'd0;
            pix_cnt   <= 28'd0;
            done_seen <= 1'b0;
            o_words   <= 24'd0;
            o_pready  <= 1'b0;
            o_e       <= 1'b0;
            o_x       <= 8'd0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_pready <= (state_nxt == FEED);
            o_e      <= xfer;
            o_x      <= xfer ? i_pdata : 8'd0;
            o_done   <= fin;
            o_err    <= start_req && size_bad;
            if (start_ok) begin
                w_q       <= i_w;
                h_q       <= i_h;
                pix_total <= size_in;
                pix_cnt   <= 28'd0;
                done_seen <= 1'b0;
                o_words   <= 24'd0;
            end else begin
                if (xfer)
                    pix_cnt <= pix_cnt + 28'd1;
                if ((state == FLUSH || state == WAIT_LAST) && enc_last_hit)
                    done_seen <= 1'b1;
                if (o_busy && i_enc_e && (o_words != 24'hFF_FFFF))
                    o_words <= o_words + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_jls_frame_sequencer.sv
// Bench for jls_frame_sequencer: size-check vector table plus directed frame
// sequences on a default instance and a NUM_BUBBLES=2 instance.
module tb_jls_frame_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_start, i_pvalid, i_enc_e, i_enc_last;
    logic [13:0] i_w, i_h;
    logic [7:0]  i_pdata;
    logic        o_pready, o_sof, o_e, o_busy, o_done, o_err;
    logic [13:0] o_w, o_h;
    logic [7:0]  o_x;
    logic [23:0] o_words;

    logic        b_start, b_pvalid, b_enc_e, b_enc_last;
    logic [13:0] b_w, b_h;
    logic [7:0]  b_pdata;
    logic        b_pready, b_sof, b_e, b_busy, b_done, b_err;
    logic [13:0] b_ow, b_oh;
    logic [7:0]  b_x;
    logic [23:0] b_words;

    int n_chk = 0;
    int n_err = 0;

    logic        t_sof[80], t_e[80], t_pr[80], t_done[80], t_busy[80], t_err[80];
    logic [7:0]  t_x[80];
    logic [13:0] t_w[80], t_h[80];
    logic [23:0] t_words[80];

    always #5 clk = ~clk;

    jls_frame_sequencer dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_w(i_w), .i_h(i_h),
        .i_pvalid(i_pvalid), .i_pdata(i_pdata), .o_pready(o_pready),
        .o_sof(o_sof), .o_w(o_w), .o_h(o_h), .o_e(o_e), .o_x(o_x),
        .i_enc_e(i_enc_e), .i_enc_last(i_enc_last), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err), .o_words(o_words)
    );

    jls_frame_sequencer #(.NUM_BUBBLES(2)) dut_b (
        .clk(clk), .rstn(rstn), .i_start(b_start), .i_w(b_w), .i_h(b_h),
        .i_pvalid(b_pvalid), .i_pdata(b_pdata), .o_pready(b_pready),
        .o_sof(b_sof), .o_w(b_ow), .o_h(b_oh), .o_e(b_e), .o_x(b_x),
        .i_enc_e(b_enc_e), .i_enc_last(b_enc_last), .o_busy(b_busy),
        .o_done(b_done), .o_err(b_err), .o_words(b_words)
    );

    typedef struct {
        logic [13:0] w;
        logic [13:0] h;
        logic        err;
        logic        busy;
        logic        sof;
        logic [13:0] ow;
        logic [13:0] oh;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic cap(input int c);
        t_sof[c] = o_sof;   t_e[c] = o_e;       t_x[c] = o_x;
        t_pr[c] = o_pready; t_done[c] = o_done; t_busy[c] = o_busy;
        t_err[c] = o_err;   t_w[c] = o_w;       t_h[c] = o_h;
        t_words[c] = o_words;
    endtask

    task automatic test_table();
        vec_t vecs[6];
        vecs[0] = '{w: 14'd3,     h: 14'd0,     err: 1'b1, busy: 1'b0, sof: 1'b0, ow: 14'd0,     oh: 14'd0};
        vecs[1] = '{w: 14'd0,     h: 14'd9,     err: 1'b1, busy: 1'b0, sof: 1'b0, ow: 14'd0,     oh: 14'd0};
        vecs[2] = '{w: 14'd4,     h: 14'd16383, err: 1'b1, busy: 1'b0, sof: 1'b0, ow: 14'd0,     oh: 14'd0};
        vecs[3] = '{w: 14'd4,     h: 14'd16382, err: 1'b0, busy: 1'b1, sof: 1'b1, ow: 14'd4,     oh: 14'd16382};
        vecs[4] = '{w: 14'd100,   h: 14'd7,     err: 1'b0, busy: 1'b1, sof: 1'b1, ow: 14'd100,   oh: 14'd7};
        vecs[5] = '{w: 14'd16383, h: 14'd0,     err: 1'b0, busy: 1'b1, sof: 1'b1, ow: 14'd16383, oh: 14'd0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            i_start = 1'b1; i_w = vecs[i].w; i_h = vecs[i].h;
            @(negedge clk);
            i_start = 1'b0;
            chk("tbl_err", o_err, vecs[i].err);
            chk("tbl_busy", o_busy, vecs[i].busy);
            chk("tbl_sof", o_sof, vecs[i].sof);
            chk("tbl_ow", o_w, vecs[i].ow);
            chk("tbl_oh", o_h, vecs[i].oh);
            @(negedge clk);
            chk("tbl_err_pulse", o_err, 1'b0);
            chk("tbl_busy_hold", o_busy, vecs[i].busy);
            do_reset();
        end
    endtask

    task automatic test_basic();
        int n_sof, n_sof_ok, n_e, n_pr, n_done, n_errp, n_leak;
        n_sof = 0; n_sof_ok = 0; n_e = 0; n_pr = 0; n_done = 0; n_errp = 0; n_leak = 0;
        @(negedge clk);
        i_start = 1'b1; i_w = 14'd4; i_h = 14'd0; i_pvalid = 1'b1; i_pdata = 8'd0;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            cap(c);
            i_start    = (c == 8) || (c == 41) || (c == 42);
            i_w        = (c == 8) ? 14'd3 : 14'd4;
            i_pdata    = 8'hA0 + 8'(c);
            i_enc_e    = (c == 5) || (c == 40);
            i_enc_last = i_enc_e;
        end
        i_start = 1'b0; i_pvalid = 1'b0; i_enc_e = 1'b0; i_enc_last = 1'b0;
        for (int c = 0; c < 43; c++) begin
            if (t_sof[c]) n_sof++;
            if (c < 13 && t_sof[c] && t_w[c] == 14'd4 && t_h[c] == 14'd0 && !t_e[c] && t_x[c] == 8'd0) n_sof_ok++;
            if (t_e[c]) n_e++;
            if (!t_e[c] && t_x[c] != 8'd0) n_leak++;
            if (!t_sof[c] && (t_w[c] != 14'd0 || t_h[c] != 14'd0)) n_leak++;
            if (t_pr[c]) n_pr++;
            if (t_done[c]) n_done++;
            if (t_err[c]) n_errp++;
        end
        chk("basic_sof_cycles", n_sof, 13);
        chk("basic_sof_fields", n_sof_ok, 13);
        chk("basic_pready_cycles", n_pr, 5);
        chk("basic_pready_first", t_pr[13], 1'b1);
        chk("basic_e_count", n_e, 5);
        for (int k = 0; k < 5; k++) begin
            chk("basic_e_pos", t_e[14+k], 1'b1);
            chk("basic_x_val", t_x[14+k], 32'hA0 + 13 + k);
        end
        chk("basic_zero_outside", n_leak, 0);
        chk("basic_err_ignored", n_errp, 0);
        chk("basic_done_count", n_done, 1);
        chk("basic_done_pos", t_done[41], 1'b1);
        chk("basic_busy_before_done", t_busy[40], 1'b1);
        chk("basic_busy_at_done", t_busy[41], 1'b0);
        chk("basic_start_on_done_ignored", t_busy[42], 1'b0);
        chk("basic_start_after_done", t_busy[43], 1'b1);
        chk("basic_words", t_words[41], 2);
        do_reset();
    endtask

    task automatic test_bubbles();
        int n_e, n_mis, n_done;
        logic exp_e, exp_pr;
        n_e = 0; n_mis = 0; n_done = 0;
        @(negedge clk);
        b_start = 1'b1; b_w = 14'd4; b_h = 14'd1; b_pvalid = 1'b1;
        for (int c = 0; c < 66; c++) begin
            @(negedge clk);
            exp_e  = (c >= 14) && (c <= 41) && ((c - 14) % 3 == 0);
            exp_pr = (c >= 13) && (c <= 40) && ((c - 13) % 3 == 0);
            if (b_e !== exp_e || b_pready !== exp_pr) n_mis++;
            if (b_x !== (exp_e ? 8'h40 + 8'(c - 1) : 8'd0)) n_mis++;
            if (b_e) n_e++;
            if (b_done) n_done++;
            if (c == 63) chk("bub_done_pos", b_done, 1'b1);
            b_start    = 1'b0;
            b_pdata    = 8'h40 + 8'(c);
            b_enc_e    = (c == 62);
            b_enc_last = b_enc_e;
        end
        b_pvalid = 1'b0; b_enc_e = 1'b0; b_enc_last = 1'b0;
        chk("bub_pattern_mismatches", n_mis, 0);
        chk("bub_e_count", n_e, 10);
        chk("bub_done_count", n_done, 1);
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        int n_mis, n_errp, n_sof_late;
        logic seen_done;
        n_mis = 0; n_errp = 0; n_sof_late = 0; seen_done = 1'b0;
        @(negedge clk);
        i_start = 1'b1; i_w = 14'd4; i_h = 14'd2; i_pvalid = 1'b0;
        i_enc_e = 1'b1; i_enc_last = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (o_e) got_q.push_back(o_x);
            if (o_err) n_errp++;
            if (c >= 13 && o_sof) n_sof_late++;
            if (o_done) begin
                seen_done = 1'b1;
                break;
            end
            i_start  = (c == 30);
            i_w      = (c == 30) ? 14'd7 : 14'd4;
            i_h      = (c == 30) ? 14'd7 : 14'd2;
            i_pvalid = 1'($urandom_range(0, 1));
            i_pdata  = 8'($urandom);
            if (o_pready && i_pvalid) exp_q.push_back(i_pdata);
        end
        i_start = 1'b0; i_pvalid = 1'b0; i_enc_e = 1'b0; i_enc_last = 1'b0;
        chk("rand_done_within_budget", seen_done, 1'b1);
        chk("rand_accepted_count", exp_q.size(), 15);
        chk("rand_pulse_count", got_q.size(), 15);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) n_mis++;
        chk("rand_x_sequence", n_mis, 0);
        chk("rand_midframe_start_err", n_errp, 0);
        chk("rand_midframe_start_sof", n_sof_late, 0);
        do_reset();
    endtask

    task automatic test_words();
        int n_done;
        n_done = 0;
        @(negedge clk);
        i_start = 1'b1; i_w = 14'd4; i_h = 14'd0; i_pvalid = 1'b1;
        for (int c = 0; c < 39; c++) begin
            @(negedge clk);
            cap(c);
            if (o_done) n_done++;
            i_start    = 1'b0;
            i_pdata    = 8'(c);
            i_enc_e    = (c <= 36);
            i_enc_last = (c == 36);
        end
        i_pvalid = 1'b0; i_enc_e = 1'b0; i_enc_last = 1'b0;
        chk("words_count", t_words[37], 37);
        chk("words_done_pos", t_done[37], 1'b1);
        chk("words_done_one_cycle", t_done[38], 1'b0);
        chk("words_done_count", n_done, 1);
        chk("words_busy_after", t_busy[38], 1'b0);
        do_reset();
    endtask

    task automatic test_reset_mid();
        int n_e, n_done_rst;
        logic seen_done;
        n_e = 0; n_done_rst = 0; seen_done = 1'b0;
        @(negedge clk);
        i_start = 1'b1; i_w = 14'd7; i_h = 14'd7; i_pvalid = 1'b1;
        i_enc_e = 1'b1; i_enc_last = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_pdata = 8'(c + 1);
        end
        chk("rst_pre_busy", o_busy, 1'b1);
        chk("rst_pre_pready", o_pready, 1'b1);
        chk("rst_pre_e", o_e, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_pready", o_pready, 1'b0);
        chk("rst_e_x", {o_e, o_x}, 9'd0);
        chk("rst_sof_w_h", {o_sof, o_w, o_h}, 29'd0);
        chk("rst_busy_done_err", {o_busy, o_done, o_err}, 3'd0);
        chk("rst_words", o_words, 24'd0);
        repeat (3) begin
            @(negedge clk);
            if (o_done) n_done_rst++;
        end
        rstn = 1'b1; i_enc_e = 1'b0;
        @(negedge clk);
        if (o_done) n_done_rst++;
        chk("rst_no_done", n_done_rst, 0);
        chk("rst_idle_after_release", o_busy, 1'b0);
        i_start = 1'b1; i_w = 14'd7; i_h = 14'd7; i_enc_e = 1'b1; i_enc_last = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_pdata = 8'(c);
            if (o_e) n_e++;
            if (o_done) begin
                seen_done = 1'b1;
                break;
            end
        end
        i_pvalid = 1'b0; i_enc_e = 1'b0; i_enc_last = 1'b0;
        chk("rst_new_frame_done", seen_done, 1'b1);
        chk("rst_new_frame_pixels", n_e, 64);
    endtask

    initial begin
        rstn = 1'b0;
        i_start = 1'b0; i_w = 14'd0; i_h = 14'd0; i_pvalid = 1'b0; i_pdata = 8'd0;
        i_enc_e = 1'b0; i_enc_last = 1'b0;
        b_start = 1'b0; b_w = 14'd0; b_h = 14'd0; b_pvalid = 1'b0; b_pdata = 8'd0;
        b_enc_e = 1'b0; b_enc_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pready", o_pready, 1'b0);
        chk("reset_sof_w_h", {o_sof, o_w, o_h}, 29'd0);
        chk("reset_e_x", {o_e, o_x}, 9'd0);
        chk("reset_busy_done_err", {o_busy, o_done, o_err}, 3'd0);
        chk("reset_words", o_words, 24'd0);
        rstn = 1'b1;
        test_table();
        test_basic();
        test_bubbles();
        test_random();
        test_words();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d, errors %0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

endmodule
